speed_loop_sequencer: RTL and testbench

Sequences the velocity PI loop of the BLDC controller. Generates the 20 kHz sample strobe (`clk_20k_enable`) and slews the speed setpoint into `desired_speed`. Double-buffers Kp/Ki so a gain pair only changes at a sample boundary. Runs the IDLE/RAMP/RUN/STOP/FAULT state machine, including a saturation watchdog that holds the PI in clear when it is not running. Sits between the AXI register file and `pi_speed_controller`.

---
 rtl/speed_loop_sequencer_pkg.sv | 37 +++
 rtl/speed_loop_sequencer_if.sv | 38 +++
 rtl/speed_loop_sequencer_tick_gen.sv | 33 +++
 rtl/speed_loop_sequencer.sv | 151 +++++++++++++++
 tb/tb_speed_loop_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/speed_loop_sequencer_pkg.sv
// Shared types for the velocity-loop sequencer: state and fault encodings,
// gain width, and the setpoint slew helper.
package speed_seq_pkg;

    localparam int GAIN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        FC_NONE = 2'd0,
        FC_EXT  = 2'd1,
        FC_SAT  = 2'd2
    } fault_code_e;

    // Moves cur toward tgt by at most step; lands exactly on tgt when close enough.
    function automatic logic signed [31:0] slew_step(
        input logic signed [31:0] cur,
        input logic signed [31:0] tgt,
        input logic signed [32:0] step
    );
        logic signed [32:0] diff;
        diff = 33'(tgt) - 33'(cur);
        if (diff > step)
            return 32'(33'(cur) + step);
        else if (diff < -step)
            return 32'(33'(cur) - step);
        else
            return tgt;
    endfunction

endpackage

// File: rtl/speed_loop_sequencer_if.sv
// Register-file / PI side signals of the sequencer, grouped as one bundle.
interface speed_loop_sequencer_if;
    import speed_seq_pkg::*;

    logic                     run_req;
    logic                     fault_in;
    logic                     fault_clr;
    logic signed [31:0]       setpoint_axi;
    logic signed [31:0]       actual_speed;
    logic                     sat_flag;
    logic        [GAIN_W-1:0] Kp_axi;
    logic        [GAIN_W-1:0] Ki_axi;
    logic                     gain_commit;
    logic                     clk_20k_enable;
    logic signed [31:0]       desired_speed;
    logic        [GAIN_W-1:0] Kp_vel_axi;
    logic        [GAIN_W-1:0] Ki_vel_axi;
    logic                     pi_clear_n;
    logic                     gain_busy;
    logic        [2:0]        state_o;
    logic                     at_speed;
    logic        [1:0]        fault_code;

    modport master (
        output run_req, fault_in, fault_clr, setpoint_axi, actual_speed,
               sat_flag, Kp_axi, Ki_axi, gain_commit,
        input  clk_20k_enable, desired_speed, Kp_vel_axi, Ki_vel_axi,
               pi_clear_n, gain_busy, state_o, at_speed, fault_code
    );

    modport slave (
        input  run_req, fault_in, fault_clr, setpoint_axi, actual_speed,
               sat_flag, Kp_axi, Ki_axi, gain_commit,
        output clk_20k_enable, desired_speed, Kp_vel_axi, Ki_vel_axi,
               pi_clear_n, gain_busy, state_o, at_speed, fault_code
    );

endinterface

// File: rtl/speed_loop_sequencer_tick_gen.sv
// Free-running divider; o_tick is a registered one-cycle strobe every DIV cycles.
module loop_tick_gen #(
    parameter int unsigned DIV = 5000
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 2;

    logic [CNT_W-1:0] r_count;
    logic             r_tick;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (r_count == CNT_W'(DIV - 1))
                r_count <= '0;
            else
                r_count <= r_count + CNT_W'(1);
            // Registered so the strobe is high exactly while r_count == DIV-1.
            r_tick <= (r_count == CNT_W'(DIV - 2));
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/speed_loop_sequencer.sv
// Velocity-loop sequencer: sample strobe, setpoint slew, double-buffered gains
// and the IDLE/RAMP/RUN/STOP/FAULT machine with saturation watchdog.
module speed_loop_sequencer
    import speed_seq_pkg::*;
#(
    parameter int unsigned      CLK_HZ    = 100_000_000,
    parameter int unsigned      LOOP_HZ   = 20_000,
    parameter int               RAMP_STEP = 64,
    parameter int               ZERO_TOL  = 2,
    parameter int unsigned      SAT_TICKS = 2000,
    parameter logic [GAIN_W-1:0] KP_INIT  = 16'h0100,
    parameter logic [GAIN_W-1:0] KI_INIT  = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    speed_loop_sequencer_if.slave io
);

    localparam int unsigned DIV   = CLK_HZ / LOOP_HZ;
    localparam int          SAT_W = $clog2(SAT_TICKS + 1);

    logic               w_tick;
    seq_state_e         r_state, w_state_nxt;
    logic signed [31:0] r_desired, w_desired_nxt, w_slew_sp, w_slew_zero;
    logic [SAT_W-1:0]   r_sat_cnt, w_sat_cnt_nxt;
    fault_code_e        r_fault_code, w_fault_code_nxt;
    logic               r_pi_clear_n, w_pi_clear_nxt;
    logic               r_at_speed, w_at_speed_nxt;
    logic               w_sat_trip, w_at_zero;
    logic [GAIN_W-1:0]  r_kp, r_ki, r_kp_pend, r_ki_pend;
    logic               r_gain_busy;

    loop_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .o_tick  (w_tick)
    );

    assign w_slew_sp   = slew_step(r_desired, io.setpoint_axi, 33'(RAMP_STEP));
    assign w_slew_zero = slew_step(r_desired, 32'sd0, 33'(RAMP_STEP));
    assign w_sat_trip  = io.sat_flag && (r_sat_cnt == SAT_W'(SAT_TICKS - 1));
    assign w_at_zero   = (io.actual_speed <= ZERO_TOL) && (io.actual_speed >= -ZERO_TOL);

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_sat_cnt_nxt = r_sat_cnt;
        if (io.fault_in) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_tick && io.run_req) w_state_nxt = ST_RAMP;
                ST_RAMP: begin
                    if (w_tick) begin
                        if (!io.run_req)                     w_state_nxt = ST_STOP;
                        else if (w_slew_sp == io.setpoint_axi) w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        w_sat_cnt_nxt = io.sat_flag ? r_sat_cnt + SAT_W'(1) : '0;
                        if (w_sat_trip)                          w_state_nxt = ST_FAULT;
                        else if (!io.run_req)                    w_state_nxt = ST_STOP;
                        else if (r_desired != io.setpoint_axi)   w_state_nxt = ST_RAMP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (io.run_req)                          w_state_nxt = ST_RAMP;
                        else if (r_desired == '0 && w_at_zero)   w_state_nxt = ST_IDLE;
                    end
                end
                ST_FAULT: if (io.fault_clr) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_state_nxt != ST_RUN)
            w_sat_cnt_nxt = '0;
    end

    // Slew target follows the state being entered, so transition ticks also step.
    always_comb begin
        w_desired_nxt    = r_desired;
        w_fault_code_nxt = r_fault_code;
        case (w_state_nxt)
            ST_RAMP, ST_RUN: if (w_tick) w_desired_nxt = w_slew_sp;
            ST_STOP:         if (w_tick) w_desired_nxt = w_slew_zero;
            default:         w_desired_nxt = '0;
        endcase
        if (w_state_nxt != ST_FAULT)
            w_fault_code_nxt = FC_NONE;
        else if (r_state != ST_FAULT)
            w_fault_code_nxt = io.fault_in ? FC_EXT : FC_SAT;
        w_pi_clear_nxt = (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_RUN) ||
                         (w_state_nxt == ST_STOP);
        w_at_speed_nxt = (w_state_nxt == ST_RUN) && (w_desired_nxt == io.setpoint_axi);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_sat_cnt    <= '0;
            r_desired    <= '0;
            r_fault_code <= FC_NONE;
            r_pi_clear_n <= 1'b0;
            r_at_speed   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sat_cnt    <= w_sat_cnt_nxt;
            r_desired    <= w_desired_nxt;
            r_fault_code <= w_fault_code_nxt;
            r_pi_clear_n <= w_pi_clear_nxt;
            r_at_speed   <= w_at_speed_nxt;
        end
    end

    // Pending equals active whenever idle, so copying on every tick is harmless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kp        <= KP_INIT;
            r_ki        <= KI_INIT;
            r_kp_pend   <= KP_INIT;
            r_ki_pend   <= KI_INIT;
            r_gain_busy <= 1'b0;
        end else begin
            if (w_tick) begin
                r_kp <= r_kp_pend;
                r_ki <= r_ki_pend;
            end
            if (io.gain_commit) begin
                r_kp_pend   <= io.Kp_axi;
                r_ki_pend   <= io.Ki_axi;
                r_gain_busy <= 1'b1;
            end else if (w_tick) begin
                r_gain_busy <= 1'b0;
            end
        end
    end

    assign io.clk_20k_enable = w_tick;
    assign io.desired_speed  = r_desired;
    assign io.Kp_vel_axi     = r_kp;
    assign io.Ki_vel_axi     = r_ki;
    assign io.pi_clear_n     = r_pi_clear_n & reset_n;
    assign io.gain_busy      = r_gain_busy;
    assign io.state_o        = r_state;
    assign io.at_speed       = r_at_speed;
    assign io.fault_code     = r_fault_code;

endmodule

// File: tb/tb_speed_loop_sequencer.sv
// Directed bench for speed_loop_sequencer, run with a 20-cycle sample period
// (CLK_HZ/LOOP_HZ = 2000/100) and a 6-sample saturation watchdog.
module tb_speed_loop_sequencer;

    localparam int DIV = 20;
    localparam int S_IDLE = 0, S_RAMP = 1, S_RUN = 2, S_STOP = 3, S_FAULT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    speed_loop_sequencer_if bus();

    speed_loop_sequencer #(
        .CLK_HZ    (2000),
        .LOOP_HZ   (100),
        .RAMP_STEP (64),
        .ZERO_TOL  (2),
        .SAT_TICKS (6),
        .KP_INIT   (16'h0100),
        .KI_INIT   (16'h0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Leaves the bench inside the next strobe cycle (sampled at negedge).
    task automatic wait_tick_cycle();
        int n = 0;
        @(negedge clk);
        while (!bus.clk_20k_enable && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", 32'(bus.clk_20k_enable), 32'd1);
    endtask

    // Leaves the bench just after the edge that ends the next strobe cycle.
    task automatic next_tick_edge();
        wait_tick_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fault_clr();
        bus.fault_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.fault_clr = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.run_req      = 1'b0;
        bus.fault_in     = 1'b0;
        bus.fault_clr    = 1'b0;
        bus.setpoint_axi = '0;
        bus.actual_speed = '0;
        bus.sat_flag     = 1'b0;
        bus.Kp_axi       = '0;
        bus.Ki_axi       = '0;
        bus.gain_commit  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", 32'(bus.clk_20k_enable), 0);
        check("rst_desired", bus.desired_speed, 0);
        check("rst_kp", 32'(bus.Kp_vel_axi), 32'h0100);
        check("rst_ki", 32'(bus.Ki_vel_axi), 32'h0000);
        check("rst_pi_clear_n", 32'(bus.pi_clear_n), 0);
        check("rst_gain_busy", 32'(bus.gain_busy), 0);
        check("rst_state", 32'(bus.state_o), S_IDLE);
        check("rst_at_speed", 32'(bus.at_speed), 0);
        check("rst_fault_code", 32'(bus.fault_code), 0);

        // Strobe timing: high in cycle DIV after release, i.e. after DIV-1 edges
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.clk_20k_enable && n < 3 * DIV);
        check("first_tick_edges", n, DIV - 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check("tick_width", 32'(bus.clk_20k_enable), 0);
        end while (!bus.clk_20k_enable && n < 3 * DIV);
        check("tick_period", n, DIV);

        // Ramp to 1000 in 64-steps
        bus.setpoint_axi = 32'sd1000;
        bus.run_req      = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            next_tick_edge();
            check($sformatf("ramp_desired_%0d", i), bus.desired_speed, (i < 16) ? 64 * i : 1000);
            if (i == 1) begin
                check("ramp_state", 32'(bus.state_o), S_RAMP);
                check("ramp_pi_clear_n", 32'(bus.pi_clear_n), 1);
                check("ramp_at_speed", 32'(bus.at_speed), 0);
            end
        end
        check("run_state", 32'(bus.state_o), S_RUN);
        check("run_at_speed", 32'(bus.at_speed), 1);

        // Gain commit mid-sample
        repeat (5) @(posedge clk);
        #1;
        bus.Kp_axi      = 16'h0200;
        bus.Ki_axi      = 16'h0010;
        bus.gain_commit = 1'b1;
        @(posedge clk);
        #1;
        bus.gain_commit = 1'b0;
        check("gain_hold_kp", 32'(bus.Kp_vel_axi), 32'h0100);
        check("gain_busy_set", 32'(bus.gain_busy), 1);
        next_tick_edge();
        check("gain_apply_kp", 32'(bus.Kp_vel_axi), 32'h0200);
        check("gain_apply_ki", 32'(bus.Ki_vel_axi), 32'h0010);
        check("gain_busy_clr", 32'(bus.gain_busy), 0);

        // Commit in the strobe cycle applies one tick later
        wait_tick_cycle();
        bus.Kp_axi      = 16'h0300;
        bus.gain_commit = 1'b1;
        @(posedge clk);
        #1;
        bus.gain_commit = 1'b0;
        check("gain_tickcommit_hold", 32'(bus.Kp_vel_axi), 32'h0200);
        check("gain_tickcommit_busy", 32'(bus.gain_busy), 1);
        next_tick_edge();
        check("gain_tickcommit_apply", 32'(bus.Kp_vel_axi), 32'h0300);

        // Back-to-back commits: last one wins
        repeat (3) @(posedge clk);
        #1;
        bus.Kp_axi = 16'h0400;
        bus.gain_commit = 1'b1;
        @(posedge clk);
        #1;
        bus.Kp_axi = 16'h0500;
        @(posedge clk);
        #1;
        bus.gain_commit = 1'b0;
        next_tick_edge();
        check("gain_overwrite_kp", 32'(bus.Kp_vel_axi), 32'h0500);
        check("gain_run_state", 32'(bus.state_o), S_RUN);

        // Stop: slew down, then IDLE on the tick after reaching 0
        bus.run_req = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            next_tick_edge();
            check($sformatf("stop_desired_%0d", j), bus.desired_speed, (j < 16) ? 1000 - 64 * j : 0);
            if (j == 1) check("stop_state", 32'(bus.state_o), S_STOP);
        end
        check("stop_still_stop", 32'(bus.state_o), S_STOP);
        next_tick_edge();
        check("stop_idle_state", 32'(bus.state_o), S_IDLE);
        check("stop_idle_pi_clear_n", 32'(bus.pi_clear_n), 0);

        // External fault during RAMP
        bus.run_req = 1'b1;
        next_tick_edge();
        next_tick_edge();
        check("fault_pre_desired", bus.desired_speed, 128);
        bus.fault_in = 1'b1;
        @(posedge clk);
        #1;
        check("fault_state", 32'(bus.state_o), S_FAULT);
        check("fault_desired", bus.desired_speed, 0);
        check("fault_code_ext", 32'(bus.fault_code), 1);
        check("fault_pi_clear_n", 32'(bus.pi_clear_n), 0);
        pulse_fault_clr();
        check("fault_clr_ignored", 32'(bus.state_o), S_FAULT);
        bus.fault_in = 1'b0;
        bus.run_req  = 1'b0;
        @(posedge clk);
        #1;
        check("fault_hold_code", 32'(bus.fault_code), 1);
        pulse_fault_clr();
        check("fault_exit_state", 32'(bus.state_o), S_IDLE);
        check("fault_exit_code", 32'(bus.fault_code), 0);

        // Saturation watchdog: trips on the 6th consecutive saturated sample
        bus.setpoint_axi = 32'sd64;
        bus.run_req      = 1'b1;
        next_tick_edge();
        next_tick_edge();
        check("sat_run_state", 32'(bus.state_o), S_RUN);
        bus.sat_flag = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            next_tick_edge();
            check($sformatf("sat_state_%0d", k), 32'(bus.state_o), (k < 6) ? S_RUN : S_FAULT);
        end
        check("sat_fault_code", 32'(bus.fault_code), 2);
        check("sat_desired", bus.desired_speed, 0);

        // One unsaturated sample before the limit restarts the count
        bus.sat_flag = 1'b0;
        pulse_fault_clr();
        check("sat_clr_state", 32'(bus.state_o), S_IDLE);
        next_tick_edge();
        next_tick_edge();
        check("sat2_run_state", 32'(bus.state_o), S_RUN);
        for (int k = 1; k <= 12; k++) begin
            bus.sat_flag = (k != 6);
            next_tick_edge();
            check($sformatf("sat2_state_%0d", k), 32'(bus.state_o), (k < 12) ? S_RUN : S_FAULT);
        end
        check("sat2_fault_code", 32'(bus.fault_code), 2);

        // Reset mid-ramp returns to IDLE with desired 0
        bus.sat_flag = 1'b0;
        pulse_fault_clr();
        bus.setpoint_axi = 32'sd1000;
        next_tick_edge();
        check("rst_ramp_pre", bus.desired_speed, 64);
        reset_n = 1'b0;
        #1;
        check("rst_ramp_state", 32'(bus.state_o), S_IDLE);
        check("rst_ramp_desired", bus.desired_speed, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
